// File: rtl/gpo_seq_pkg.sv
// Shared types and GPO register map for the GPO pattern sequencer.
package gpo_seq_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_SETUP  = 3'd1,
        SEQ_ACCESS = 3'd2,
        SEQ_DWELL  = 3'd3,
        SEQ_DONE   = 3'd4
    } seq_state_e;

    typedef enum logic [1:0] {
        XFER_MODE = 2'd0,
        XFER_DATA = 2'd1,
        XFER_READ = 2'd2
    } xfer_kind_e;

    localparam logic [2:0] GPO_MODE_ADDR  = 3'h0;
    localparam logic [2:0] GPO_ODATA_ADDR = 3'h4;

    typedef struct packed {
        logic [2:0]  addr;
        logic        write;
        logic [31:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/apb_master_xfer.sv
// Single-transfer APB master: a one-cycle i_req is the SETUP phase, then ACCESS is held until PREADY.
module apb_master_xfer
    import gpo_seq_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  apb_req_t    i_req_data,
    input  logic        i_pready,
    output logic        o_ack,
    output logic        o_psel,
    output logic        o_penable,
    output logic        o_pwrite,
    output logic [2:0]  o_paddr,
    output logic [31:0] o_pwdata
);

    logic     r_active;
    apb_req_t r_req;
    apb_req_t w_cur;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active <= 1'b0;
            r_req    <= '0;
        end else if (r_active) begin
            if (i_pready)
                r_active <= 1'b0;
        end else if (i_req) begin
            r_active <= 1'b1;
            r_req    <= i_req_data;
        end
    end

    // SETUP is driven straight from the request so PSEL rises in the requester's SETUP cycle.
    assign w_cur     = (i_req && !r_active) ? i_req_data : r_req;
    assign o_psel    = r_active | i_req;
    assign o_penable = r_active;
    assign o_pwrite  = w_cur.write;
    assign o_paddr   = w_cur.addr;
    assign o_pwdata  = w_cur.wdata;
    assign o_ack     = r_active & i_pready;

endmodule

// File: rtl/gpo_pattern_sequencer.sv
// Steps a latched 4-bit pattern table into the GPO out_data register over APB with a dwell per step.
// Optional GPO_READBACK_CHECK_EN: read back each out_data write and abort with sticky err on mismatch.
module gpo_pattern_sequencer
    import gpo_seq_pkg::*;
#(
    parameter int NUM_STEPS = 8,
    parameter int DWELL_W   = 16,
    parameter int REP_W     = 8
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         start,
    input  logic                         stop,
    input  logic [3:0]                   mode_mask,
    input  logic [4*NUM_STEPS-1:0]       pattern,
    input  logic [DWELL_W-1:0]           dwell,
    input  logic [REP_W-1:0]             repeats,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx,
    output logic                         err,
    output logic [2:0]                   PADDR,
    output logic                         PWRITE,
    output logic                         PSEL,
    output logic                         PENABLE,
    output logic [31:0]                  PWDATA,
    input  logic [31:0]                  PRDATA,
    input  logic                         PREADY
);

    localparam int STEP_W = $clog2(NUM_STEPS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    seq_state_e             r_state;
    xfer_kind_e             r_kind;
    logic [3:0]             r_mask;
    logic [4*NUM_STEPS-1:0] r_pattern;
    logic [DWELL_W-1:0]     r_dwell;
    logic [DWELL_W-1:0]     r_cnt;
    logic [REP_W-1:0]       r_rep;
    logic [REP_W-1:0]       r_pass;
    logic [STEP_W-1:0]      r_step;
    logic                   r_stop_req;

    logic                   w_ack;
    logic                   w_req;
    apb_req_t               w_req_data;
    logic [3:0]             w_cur_pat;
    logic                   w_dwell_last;
    logic [REP_W-1:0]       w_pass_nxt;
    logic                   w_rep_hit;

    assign w_cur_pat    = r_pattern[{r_step, 2'b00} +: 4];
    assign w_dwell_last = (r_dwell == '0) || (r_cnt == r_dwell - DWELL_W'(1));
    assign w_pass_nxt   = r_pass + REP_W'(1);
    assign w_rep_hit    = (r_rep != '0) && (w_pass_nxt == r_rep);
    assign w_req        = (r_state == SEQ_SETUP);

    always_comb begin
        w_req_data = '0;
        case (r_kind)
            XFER_MODE: begin
                w_req_data.addr  = GPO_MODE_ADDR;
                w_req_data.write = 1'b1;
                w_req_data.wdata = {28'b0, r_mask};
            end
            XFER_DATA: begin
                w_req_data.addr  = GPO_ODATA_ADDR;
                w_req_data.write = 1'b1;
                w_req_data.wdata = {28'b0, w_cur_pat};
            end
            default: begin
                w_req_data.addr  = GPO_ODATA_ADDR;
                w_req_data.write = 1'b0;
            end
        endcase
    end

`ifdef GPO_READBACK_CHECK_EN
    logic r_err;
    logic w_rb_ok;
    logic w_unused_prdata;
    assign w_rb_ok         = (PRDATA[3:0] == w_cur_pat);
    assign w_unused_prdata = ^PRDATA[31:4];
    assign err             = r_err;
`else
    logic w_unused_prdata;
    assign w_unused_prdata = ^PRDATA;
    assign err             = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_state    <= SEQ_IDLE;
            r_kind     <= XFER_MODE;
            r_mask     <= '0;
            r_pattern  <= '0;
            r_dwell    <= '0;
            r_cnt      <= '0;
            r_rep      <= '0;
            r_pass     <= '0;
            r_step     <= '0;
            r_stop_req <= 1'b0;
`ifdef GPO_READBACK_CHECK_EN
            r_err      <= 1'b0;
`endif
        end else begin
            case (r_state)
                SEQ_IDLE: begin
                    if (start) begin
                        r_mask     <= mode_mask;
                        r_pattern  <= pattern;
                        r_dwell    <= dwell;
                        r_rep      <= repeats;
                        r_step     <= '0;
                        r_pass     <= '0;
                        r_cnt      <= '0;
                        r_kind     <= XFER_MODE;
                        r_stop_req <= 1'b0;
                        r_state    <= SEQ_SETUP;
                    end
                end
                SEQ_SETUP: begin
                    if (stop)
                        r_stop_req <= 1'b1;
                    r_state <= SEQ_ACCESS;
                end
                SEQ_ACCESS: begin
                    if (stop)
                        r_stop_req <= 1'b1;
                    if (w_ack) begin
                        r_cnt <= '0;
                        case (r_kind)
                            XFER_MODE: begin
                                r_kind  <= XFER_DATA;
                                r_state <= SEQ_SETUP;
                            end
                            XFER_DATA: begin
`ifdef GPO_READBACK_CHECK_EN
                                r_kind  <= XFER_READ;
                                r_state <= SEQ_SETUP;
`else
                                r_state <= SEQ_DWELL;
`endif
                            end
`ifdef GPO_READBACK_CHECK_EN
                            XFER_READ: begin
                                r_kind <= XFER_DATA;
                                if (!w_rb_ok) begin
                                    r_err   <= 1'b1;
                                    r_state <= SEQ_DONE;
                                end else begin
                                    r_state <= SEQ_DWELL;
                                end
                            end
`endif
                            default: r_state <= SEQ_DONE;
                        endcase
                        // A pending stop overrides whatever follows the finished transfer.
                        if (r_stop_req || stop)
                            r_state <= SEQ_DONE;
                    end
                end
                SEQ_DWELL: begin
                    if (stop) begin
                        r_state <= SEQ_DONE;
                    end else if (w_dwell_last) begin
                        r_cnt <= '0;
                        if (r_step == LAST_STEP) begin
                            r_step  <= '0;
                            r_pass  <= w_pass_nxt;
                            r_state <= w_rep_hit ? SEQ_DONE : SEQ_SETUP;
                        end else begin
                            r_step  <= r_step + STEP_W'(1);
                            r_state <= SEQ_SETUP;
                        end
                    end else begin
                        r_cnt <= r_cnt + DWELL_W'(1);
                    end
                end
                SEQ_DONE: begin
                    r_stop_req <= 1'b0;
                    r_state    <= SEQ_IDLE;
                end
                default: r_state <= SEQ_IDLE;
            endcase
        end
    end

    apb_master_xfer u_xfer (
        .i_clk      (PCLK),
        .i_rst_n    (PRESET),
        .i_req      (w_req),
        .i_req_data (w_req_data),
        .i_pready   (PREADY),
        .o_ack      (w_ack),
        .o_psel     (PSEL),
        .o_penable  (PENABLE),
        .o_pwrite   (PWRITE),
        .o_paddr    (PADDR),
        .o_pwdata   (PWDATA)
    );

    assign busy     = (r_state != SEQ_IDLE) && (r_state != SEQ_DONE);
    assign done     = (r_state == SEQ_DONE);
    assign step_idx = r_step;

endmodule
